// File: rtl/async_fifo.sv
// Gray-pointer FIFO with registered full/empty flags, single clock for now.
// Define ASY_FIFO_SYNC_EN to pass each Gray pointer through a two-flop synchronizer.
module async_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             fifo_empty,
  output logic             fifo_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW:0] wr_bin, rd_bin;
  logic [AW:0] wr_gray, rd_gray;
  logic [AW:0] wq_gray, rq_gray;
  logic [AW:0] wr_bin_next, rd_bin_next;
  logic [AW:0] wr_gray_next, rd_gray_next;
  logic        wr_accept, rd_accept;

  assign wr_accept    = wr_en && !fifo_full;
  assign rd_accept    = rd_en && !fifo_empty;
  assign wr_bin_next  = wr_bin + {{AW{1'b0}}, wr_accept};
  assign rd_bin_next  = rd_bin + {{AW{1'b0}}, rd_accept};
  assign wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1);
  assign rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1);

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_bin[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_accept) begin
      rd_data <= mem[rd_bin[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bin     <= '0;
      wr_gray    <= '0;
      fifo_full  <= 1'b0;
    end else begin
      wr_bin     <= wr_bin_next;
      wr_gray    <= wr_gray_next;
      // Full when the write pointer laps the read pointer: top two Gray bits inverted.
      fifo_full  <= (wr_gray_next == {~rq_gray[AW:AW-1], rq_gray[AW-2:0]});
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_bin     <= '0;
      rd_gray    <= '0;
      fifo_empty <= 1'b1;
    end else begin
      rd_bin     <= rd_bin_next;
      rd_gray    <= rd_gray_next;
      fifo_empty <= (rd_gray_next == wq_gray);
    end
  end

`ifdef ASY_FIFO_SYNC_EN
  logic [AW:0] wq_sync, rq_sync;
  logic [AW:0] wq_sync2, rq_sync2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wq_sync  <= '0;
      wq_sync2 <= '0;
      rq_sync  <= '0;
      rq_sync2 <= '0;
    end else begin
      wq_sync  <= wr_gray;
      wq_sync2 <= wq_sync;
      rq_sync  <= rd_gray;
      rq_sync2 <= rq_sync;
    end
  end

  assign wq_gray = wq_sync2;
  assign rq_gray = rq_sync2;
`else
  assign wq_gray = wr_gray;
  assign rq_gray = rd_gray;
`endif

endmodule

// File: tb/tb_async_fifo.sv
// Directed bench for async_fifo: a queue scoreboard tracks accepted writes
// and checks every accepted read, plus flag timing at the boundaries.
module tb_async_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
`ifdef ASY_FIFO_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic             clk;
  logic             rst_n;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             fifo_empty;
  logic             fifo_full;

  async_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [WIDTH-1:0] sb [$];
  int               cnt;
  logic [WIDTH-1:0] last_rd;
  int               compared;
  int               mismatched;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, let the edge pass, then check against the model.
  task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r);
    logic             wacc;
    logic             racc;
    logic [WIDTH-1:0] exp_rd;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    wacc = w && (cnt < DEPTH);
    racc = r && (cnt > 0);
    if (wacc) sb.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (racc) begin
      exp_rd  = sb.pop_front();
      last_rd = exp_rd;
      chk("rd_data", 32'(rd_data), 32'(exp_rd));
    end else begin
      chk("rd_hold", 32'(rd_data), 32'(last_rd));
    end
    cnt = cnt + int'(wacc) - int'(racc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  task automatic model_reset();
    sb.delete();
    cnt     = 0;
    last_rd = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] v;
    compared   = 0;
    mismatched = 0;
    wr_en      = 1'b0;
    wr_data    = '0;
    rd_en      = 1'b0;
    model_reset();

    // Reset held for two edges
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_empty", 32'(fifo_empty), 32'd1);
    chk("reset_full", 32'(fifo_full), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Fill with random values, then drain
    for (int i = 0; i < DEPTH; i++) begin
      v = 8'($urandom_range(29, 0));
      step(1'b1, v, 1'b0);
      if (i == DEPTH - 2) chk("fill_full_early", 32'(fifo_full), 32'd0);
    end
    chk("fill_full", 32'(fifo_full), 32'd1);
    for (int k = 1; k <= DEPTH; k++) begin
      step(1'b0, '0, 1'b1);
      chk("drain_full", 32'(fifo_full), (k < 1 + LAT) ? 32'd1 : 32'd0);
      if (k == DEPTH - 1) chk("drain_empty_early", 32'(fifo_empty), 32'd0);
    end
    chk("drain_empty", 32'(fifo_empty), 32'd1);
    idle(4);

    // Overflow: sixteen writes, only the first DEPTH stick
    for (int i = 1; i <= 2 * DEPTH; i++) begin
      step(1'b1, 8'(i), 1'b0);
      if (i >= DEPTH) chk("ovf_full", 32'(fifo_full), 32'd1);
    end
    idle(4);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
    chk("ovf_drain_empty", 32'(fifo_empty), 32'd1);
    idle(4);

    // Underflow: reads on an empty FIFO change nothing
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1);
      chk("udf_empty", 32'(fifo_empty), 32'd1);
    end
    idle(2);

    // Streaming at occupancy four across pointer wrap
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom_range(255, 0)), 1'b0);
    idle(4);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'($urandom_range(255, 0)), 1'b1);
      chk("stream_empty", 32'(fifo_empty), 32'd0);
      chk("stream_full", 32'(fifo_full), 32'd0);
    end
    chk("stream_count", 32'(cnt), 32'd4);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    chk("stream_drain_empty", 32'(fifo_empty), 32'd1);
    idle(4);

    // Reset mid-operation discards contents
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    idle(4);
    chk("pre_rst_empty", 32'(fifo_empty), 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    chk("mid_rst_empty", 32'(fifo_empty), 32'd1);
    chk("mid_rst_full", 32'(fifo_full), 32'd0);
    chk("mid_rst_rd_data", 32'(rd_data), 32'd0);
    step(1'b0, '0, 1'b1);
    chk("post_rst_read_empty", 32'(fifo_empty), 32'd1);

    // FIFO still usable afterwards
    step(1'b1, 8'h5a, 1'b0);
    idle(4);
    step(1'b0, '0, 1'b1);
    chk("final_empty", 32'(fifo_empty), 32'd1);
    chk("final_scoreboard", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
